freq_meter_ctrl: RTL and testbench
==================================

# freq_meter_ctrl

Measurement sequencer for the 4-digit BCD frequency counter. It generates the counter's gate enable, clear and store strobes, and the 2-bit range/status code on the system clock. In auto mode it steps the gate time up or down after each measurement from the counter's overflow and leading-digit-zero indications. It sits between the timebase/user controls and the BCD counter bank; its outputs drive the counter's En, Clear, Store and Status_Value inputs.

## Interface

Parameters:
- TICK_DIV, 1000 — CP cycles per gate unit (1 unit = 1 ms at 1 MHz CP).
- SETTLE_CYC, 4 — CP cycles between gate close and Store, so in-flight counts can land.
- HOLD_UNITS, 500 — display hold time in gate units.

Ports:
- CP, input, 1 — system clock; all logic is on the rising edge.
- nRST, input, 1 — reset, synchronous, active-low.
- Auto, input, 1 — 1 selects auto-ranging; 0 selects manual range.
- Manual_Range, input, 2 — range used when Auto=0.
- Overflow, input, 1 — counter exceeded 9999 in the current gate. Level, already synchronous to CP.
- Msd_Zero, input, 1 — BCD3==0. Level, synchronous to CP.
- En, output, 1 — gate enable to the counter.
- Clear, output, 1 — one-cycle counter clear.
- Store, output, 1 — one-cycle latch strobe to the counter's display registers.
- Status_Value, output, 2 — current range: 0=1000, 1=100, 2=10, 3=1 gate units.
- Valid, output, 1 — pulses together with Store.
- Over_Range, output, 1 — sticky flag: overflow occurred at range 3.
- Busy, output, 1 — high in every state except HOLD.

## Operation

- States: INIT → CLEAR → GATE → SETTLE → STORE → HOLD → CLEAR, and so on.
- All outputs are registered and decoded from the state register (Moore).
- INIT:
  - One cycle. All outputs 0, range 0, all internal counters 0.
- CLEAR:
  - One cycle, Clear=1.
  - Range is loaded here: Manual_Range if Auto=0, otherwise the pending auto range.
  - Status_Value updates on the transition into GATE.
- GATE:
  - En=1 for exactly G = units(range) × TICK_DIV cycles.
  - Built from a prescaler counting 0..TICK_DIV-1 and a 10-bit unit counter.
- SETTLE:
  - En=0 for SETTLE_CYC cycles.
  - Overflow and Msd_Zero are sampled on the last SETTLE cycle. Decision:
    - Auto=1, Overflow=1, range<3: pending range = range+1. Go directly to CLEAR with no Store; the result is discarded.
    - Overflow=1 with range==3 (any mode): go to STORE and set Over_Range=1.
    - Auto=1, Overflow=0, Msd_Zero=1, range>0: go to STORE; pending range = range-1.
    - Otherwise: go to STORE; pending range unchanged.
- STORE:
  - One cycle, Store=1 and Valid=1.
  - Over_Range clears here if Overflow=0.
- HOLD:
  - HOLD_UNITS × TICK_DIV cycles, all strobes 0, Busy=0.
- Mode changes: a change of Auto or Manual_Range mid-cycle takes effect only at the next CLEAR. Switching Auto 1→0 discards the pending auto range.

## Timing

- Reset values, applied at the first CP edge with nRST=0: state INIT; En=Clear=Store=Valid=Over_Range=Busy=0; Status_Value=0.
- While nRST=0, the block stays in INIT.
- First Clear is asserted 2 cycles after the first edge with nRST=1 (INIT, then CLEAR).
- Normal cycle length: 1 + G + SETTLE_CYC + 1 + HOLD_UNITS×TICK_DIV. Discarded cycle length: 1 + G + SETTLE_CYC.
- En is high for exactly G consecutive cycles. There are no glitches and no overlap with Clear or Store.
- Clear and Store are never high in the same cycle.
- Range can move at most one step per measurement. Range saturates at 0 and 3; there is no wrap-around.
- Reset mid-GATE: En drops on the reset edge and no Store is issued.

## Test plan

Bench parameters: TICK_DIV=2, SETTLE_CYC=2, HOLD_UNITS=3.

- Reset, then Auto=0, Manual_Range=3, Overflow=0 → Clear at cycle 2; En high for 2 cycles; Store/Valid 2 cycles after En falls; period 12 cycles repeating; Busy low for 6 cycles per period.
- Auto=1, start range 0, Overflow=1 for three gates → no Store; Status_Value steps 0→1→2→3; the next gate lasts 2 cycles.
- Auto=1 at range 3, Overflow=1 → Store pulses and Over_Range=1; next measurement with Overflow=0 → Over_Range=0 at its Store.
- Auto=1 at range 2, Overflow=0, Msd_Zero=1 → Store pulses; next gate uses range 1 (200 cycles of En).
- Assert nRST=0 for one cycle in the middle of GATE → En=0 on the next edge; no Store; Status_Value=0; INIT then Clear 2 cycles after release.
- Auto=0, change Manual_Range from 1 to 3 mid-GATE → current gate completes at 200 cycles; next gate is 2 cycles.

Source files
------------

// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the 4-digit BCD frequency counter: gate, clear and store strobes,
// plus auto-ranging of the gate time from the counter's overflow / leading-zero indications.
module freq_meter_ctrl #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned HOLD_UNITS = 500
) (
    input  logic       CP,
    input  logic       nRST,
    input  logic       Auto,
    input  logic [1:0] Manual_Range,
    input  logic       Overflow,
    input  logic       Msd_Zero,
    output logic       En,
    output logic       Clear,
    output logic       Store,
    output logic [1:0] Status_Value,
    output logic       Valid,
    output logic       Over_Range,
    output logic       Busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [9:0]    HOLD_LAST   = 10'(HOLD_UNITS - 1);

    typedef enum logic [2:0] {
        StInit,
        StClear,
        StGate,
        StSettle,
        StStore,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    unit_q, unit_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [1:0]    range_q, range_d;
    logic [1:0]    pend_q, pend_d;
    logic          over_d;
    logic          tick_last;
    logic [9:0]    gate_last;

    // Gate length in units for each range code (range 0 is the longest gate).
    function automatic logic [9:0] gate_units(input logic [1:0] r);
        logic [9:0] u;
        u = 10'd1;
        case (r)
            2'd0: u = 10'd1000;
            2'd1: u = 10'd100;
            2'd2: u = 10'd10;
            2'd3: u = 10'd1;
        endcase
        return u;
    endfunction

    assign tick_last = (presc_q == PRESC_LAST);
    assign gate_last = gate_units(range_q) - 10'd1;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        unit_d   = unit_q;
        settle_d = settle_q;
        range_d  = range_q;
        pend_d   = pend_q;
        over_d   = Over_Range;

        case (state_q)
            StInit: begin
                presc_d  = '0;
                unit_d   = '0;
                settle_d = '0;
                range_d  = 2'd0;
                pend_d   = 2'd0;
                over_d   = 1'b0;
                state_d  = StClear;
            end

            StClear: begin
                // Manual mode overwrites the pending auto range, discarding it.
                range_d = Auto ? pend_q : Manual_Range;
                pend_d  = range_d;
                presc_d = '0;
                unit_d  = '0;
                state_d = StGate;
            end

            StGate: begin
                if (tick_last) begin
                    presc_d = '0;
                    if (unit_q == gate_last) begin
                        unit_d   = '0;
                        settle_d = '0;
                        state_d  = StSettle;
                    end else begin
                        unit_d = unit_q + 10'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            StSettle: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = StStore;
                    if (Auto && Overflow && (range_q != 2'd3)) begin
                        // Overflowed at a longer gate than needed: discard and retry shorter.
                        pend_d  = range_q + 2'd1;
                        state_d = StClear;
                    end else if (Overflow && (range_q == 2'd3)) begin
                        over_d = 1'b1;
                    end else if (Auto && !Overflow && Msd_Zero && (range_q != 2'd0)) begin
                        pend_d = range_q - 2'd1;
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            StStore: begin
                if (!Overflow) begin
                    over_d = 1'b0;
                end
                presc_d = '0;
                unit_d  = '0;
                state_d = StHold;
            end

            StHold: begin
                if (tick_last) begin
                    presc_d = '0;
                    if (unit_q == HOLD_LAST) begin
                        unit_d  = '0;
                        state_d = StClear;
                    end else begin
                        unit_d = unit_q + 10'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (!nRST) begin
            state_q  <= StInit;
            presc_q  <= '0;
            unit_q   <= '0;
            settle_q <= '0;
            range_q  <= 2'd0;
            pend_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            unit_q   <= unit_d;
            settle_q <= settle_d;
            range_q  <= range_d;
            pend_q   <= pend_d;
        end
    end

    // Outputs are registered decodes of the state register, one cycle behind it.
    always_ff @(posedge CP) begin
        if (!nRST) begin
            En           <= 1'b0;
            Clear        <= 1'b0;
            Store        <= 1'b0;
            Valid        <= 1'b0;
            Busy         <= 1'b0;
            Status_Value <= 2'd0;
            Over_Range   <= 1'b0;
        end else begin
            En           <= (state_q == StGate);
            Clear        <= (state_q == StClear);
            Store        <= (state_q == StStore);
            Valid        <= (state_q == StStore);
            Busy         <= (state_q != StHold) && (state_q != StInit);
            Status_Value <= range_q;
            Over_Range   <= over_d;
        end
    end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Self-checking bench for freq_meter_ctrl: table of measurements checked through an expected-result
// queue, plus hand-written sequences for reset timing, reset mid-gate and mid-gate range change.
module tb_freq_meter_ctrl;

    localparam int unsigned TICK_DIV   = 2;
    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned HOLD_UNITS = 3;
    localparam int          TMO        = 3000;
    localparam int          NV         = 14;

    logic       CP = 1'b0;
    logic       nRST;
    logic       Auto;
    logic [1:0] Manual_Range;
    logic       Overflow;
    logic       Msd_Zero;
    logic       En;
    logic       Clear;
    logic       Store;
    logic [1:0] Status_Value;
    logic       Valid;
    logic       Over_Range;
    logic       Busy;

    freq_meter_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .SETTLE_CYC(SETTLE_CYC),
        .HOLD_UNITS(HOLD_UNITS)
    ) dut (
        .CP          (CP),
        .nRST        (nRST),
        .Auto        (Auto),
        .Manual_Range(Manual_Range),
        .Overflow    (Overflow),
        .Msd_Zero    (Msd_Zero),
        .En          (En),
        .Clear       (Clear),
        .Store       (Store),
        .Status_Value(Status_Value),
        .Valid       (Valid),
        .Over_Range  (Over_Range),
        .Busy        (Busy)
    );

    always #5 CP = ~CP;

    typedef struct {
        bit         auto_m;
        logic [1:0] man;
        bit         ovf;
        bit         msdz;
        int         exp_len;
        logic [1:0] exp_st;
        bit         exp_store;
        bit         exp_over;
    } vec_t;

    vec_t vecs[NV];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        Auto         = v.auto_m;
        Manual_Range = v.man;
        Overflow     = v.ovf;
        Msd_Zero     = v.msdz;
        exp_q.push_back(v);
    endtask

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge CP);
            if (En) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns on the first sample with En low after a gate.
    task automatic measure_gate(output int len, output logic [1:0] st, output bit ok);
        len = 0;
        st  = 2'd0;
        wait_rise(ok);
        if (!ok) return;
        st  = Status_Value;
        len = 1;
        ok  = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge CP);
            if (!En) begin
                ok = 1'b1;
                break;
            end
            len++;
        end
    endtask

    // {Clear, En, Store, Valid, Busy} expected k cycles after reset release, manual range 3.
    function automatic logic [4:0] h1_expect(input int k);
        int p;
        if (k < 2) return 5'b00000;
        p = (k - 2) % 12;
        return {p == 0, (p == 1) || (p == 2), p == 5, p == 5, p < 6};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         len;
        logic [1:0] st;
        bit         ok;
        bit         early;
        vec_t       e;
        logic [4:0] got;

        //              auto  man    ovf   msdz  len   st     store over
        vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 200,  2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b1, 1'b0, 20,   2'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2,    2'd3, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 2,    2'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 1'b1, 2,    2'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b1, 20,   2'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 200,  2'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b1, 200,  2'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 2000, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 2000, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 1'b1, 1'b0, 20,   2'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'd3, 1'b1, 1'b0, 2,    2'd3, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 1'b0, 2,    2'd3, 1'b1, 1'b0};

        // Reset values
        nRST = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge CP);
        got = {Clear, En, Store, Valid, Busy};
        check("reset strobes", int'(got), 0);
        check("reset status", int'(Status_Value), 0);
        check("reset over_range", int'(Over_Range), 0);
        nRST = 1'b1;

        // Table-driven measurements
        for (int i = 0; i < NV; i++) begin
            measure_gate(len, st, ok);
            check($sformatf("v%0d gate seen", i), int'(ok), 1);
            e = exp_q.pop_front();
            check($sformatf("v%0d gate_len", i), len, e.exp_len);
            check($sformatf("v%0d status", i), int'(st), int'(e.exp_st));
            early = Store;
            @(negedge CP);
            early = early | Store;
            if (!e.exp_store && (i + 1 < NV)) drive(vecs[i + 1]);
            @(negedge CP);
            check($sformatf("v%0d store_early", i), int'(early), 0);
            check($sformatf("v%0d store", i), int'(Store), int'(e.exp_store));
            check($sformatf("v%0d valid", i), int'(Valid), int'(e.exp_store));
            check($sformatf("v%0d clear", i), int'(Clear), int'(!e.exp_store));
            if (e.exp_store) check($sformatf("v%0d over_range", i), int'(Over_Range),
                                   int'(e.exp_over));
            if (e.exp_store && (i + 1 < NV)) drive(vecs[i + 1]);
        end

        // Manual range 3: strobe pattern and 12-cycle period after reset release
        @(negedge CP);
        nRST = 1'b0;
        Auto = 1'b0;
        Manual_Range = 2'd3;
        Overflow = 1'b0;
        Msd_Zero = 1'b0;
        @(negedge CP);
        got = {Clear, En, Store, Valid, Busy};
        check("h1 reset strobes", int'(got), 0);
        nRST = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge CP);
            got = {Clear, En, Store, Valid, Busy};
            check($sformatf("h1 k=%0d strobes", k), int'(got), int'(h1_expect(k)));
        end

        // Reset in the middle of a 200-cycle gate
        nRST = 1'b0;
        Manual_Range = 2'd1;
        @(negedge CP);
        nRST = 1'b1;
        wait_rise(ok);
        check("h2 gate seen", int'(ok), 1);
        repeat (50) @(negedge CP);
        check("h2 en mid gate", int'(En), 1);
        check("h2 status mid gate", int'(Status_Value), 1);
        nRST = 1'b0;
        @(negedge CP);
        check("h2 en after reset", int'(En), 0);
        check("h2 status after reset", int'(Status_Value), 0);
        check("h2 store after reset", int'(Store), 0);
        nRST = 1'b1;
        @(negedge CP);
        check("h2 k1 clear", int'(Clear), 0);
        check("h2 k1 store", int'(Store), 0);
        @(negedge CP);
        check("h2 k2 clear", int'(Clear), 1);

        // Manual_Range change mid-gate takes effect only at the next Clear
        wait_rise(ok);
        check("h3 gate seen", int'(ok), 1);
        st  = Status_Value;
        len = 1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge CP);
            if (!En) break;
            len++;
            if (len == 100) Manual_Range = 2'd3;
        end
        check("h3 first gate_len", len, 200);
        check("h3 first status", int'(st), 1);
        measure_gate(len, st, ok);
        check("h3 second gate seen", int'(ok), 1);
        check("h3 second gate_len", len, 2);
        check("h3 second status", int'(st), 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
